// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
// FSM state encoding, word geometry, wait counter width and the
// byte-address to word-index conversion used by the responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    localparam int WORD_BYTES = 32'sd4;
    localparam int BYTE_W     = 32'sd8;
    localparam int DMEM_LAT_W = 32'sd4;

    // Word offset of a byte address relative to the window base.
    // Callers truncate the result to their index width.
    function automatic logic [31:0] addr_to_index(input logic [31:0] addr,
                                                  input logic [31:0] base);
        return (addr - base) >> 32'd2;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response handshake bundle between a core's
// load/store port (master) and the data-memory responder (slave).
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_array.sv
// dmem_array: synchronous 32-bit word storage with byte-masked writes.
// Read data is registered on every edge from the presented index; the
// storage itself is never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clock,
    input  logic                           we,
    input  logic [3:0]                     be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem_r [DEPTH_WORDS];
    logic [31:0] rdata_r;

    // Byte-masked write of the enabled lanes only
    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (be[b]) begin
                    mem_r[idx][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Registered read of the addressed word (old contents on a same-edge write)
    always_ff @(posedge clock) begin
        rdata_r <= mem_r[idx];
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for processor data accesses.
// Accepts one request at a time, waits LATENCY cycles, performs the
// byte-enabled access and holds the response until it is taken.
// Optional feature macro: DMEM_RESP_ERR_CHECK_EN enables alignment and
// address-window checking; without it resp_err is 0 and the word index
// wraps modulo DEPTH_WORDS.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset,
    dmem_responder_if.slave bus
);

    localparam int                    IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [DMEM_LAT_W-1:0] LAT_LOAD = DMEM_LAT_W'(LATENCY - 32'sd1);
    localparam bit                    LAT_ZERO = (LATENCY == 32'sd0);

    dmem_state_e           state_r;
    logic [DMEM_LAT_W-1:0] cnt_r;
    logic                  write_r;
    logic [31:0]           addr_r;
    logic [31:0]           wdata_r;
    logic [3:0]            be_r;
    logic                  resp_valid_r;
    logic                  err_r;
    logic                  load_ok_r;

    logic                  acc_write_s;
    logic [31:0]           acc_addr_s;
    logic [31:0]           acc_wdata_s;
    logic [3:0]            acc_be_s;
    logic                  addr_err_s;
    logic                  commit_s;
    logic                  arr_we_s;
    logic [IDX_W-1:0]      idx_s;
    logic [31:0]           arr_rdata_s;

    // Access fields: live bus in IDLE so a zero-latency access can commit on
    // the acceptance edge, the latched copy in every other state
    always_comb begin
        if (state_r == ST_IDLE) begin
            acc_write_s = bus.req_write;
            acc_addr_s  = bus.req_addr;
            acc_wdata_s = bus.req_wdata;
            acc_be_s    = bus.req_be;
        end else begin
            acc_write_s = write_r;
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
            acc_be_s    = be_r;
        end
    end

`ifdef DMEM_RESP_ERR_CHECK_EN
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * WORD_BYTES);
    logic [32:0] off_s;

    assign off_s = {1'b0, acc_addr_s} - {1'b0, BASE_ADDR};

    // Misaligned, below-base (borrow) or beyond-window addresses are errors
    always_comb begin
        if (acc_addr_s[1:0] != 2'b00) begin
            addr_err_s = 1'b1;
        end else if (off_s[32]) begin
            addr_err_s = 1'b1;
        end else if (off_s[31:0] >= SPAN_BYTES) begin
            addr_err_s = 1'b1;
        end else begin
            addr_err_s = 1'b0;
        end
    end
`else
    assign addr_err_s = 1'b0;
`endif

    // The access edge is the one that moves the FSM into RESP
    always_comb begin
        if (state_r == ST_IDLE) begin
            commit_s = bus.req_valid && LAT_ZERO;
        end else if (state_r == ST_WAIT) begin
            commit_s = (cnt_r == {DMEM_LAT_W{1'b0}});
        end else begin
            commit_s = 1'b0;
        end
    end

    // Reset blocks the write so an aborted store can never land
    assign arr_we_s = commit_s && acc_write_s && !addr_err_s && !reset;
    assign idx_s    = IDX_W'(addr_to_index(acc_addr_s, BASE_ADDR));

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clock (clock),
        .we    (arr_we_s),
        .be    (acc_be_s),
        .idx   (idx_s),
        .wdata (acc_wdata_s),
        .rdata (arr_rdata_s)
    );

    // Control FSM with request latches, wait counter and response flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {DMEM_LAT_W{1'b0}};
            write_r      <= 1'b0;
            addr_r       <= 32'h0000_0000;
            wdata_r      <= 32'h0000_0000;
            be_r         <= 4'b0000;
            resp_valid_r <= 1'b0;
            err_r        <= 1'b0;
            load_ok_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        write_r <= bus.req_write;
                        addr_r  <= bus.req_addr;
                        wdata_r <= bus.req_wdata;
                        be_r    <= bus.req_be;
                        if (LAT_ZERO) begin
                            state_r      <= ST_RESP;
                            resp_valid_r <= 1'b1;
                            err_r        <= addr_err_s;
                            load_ok_r    <= !acc_write_s && !addr_err_s;
                        end else begin
                            cnt_r   <= LAT_LOAD;
                            state_r <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == {DMEM_LAT_W{1'b0}}) begin
                        state_r      <= ST_RESP;
                        resp_valid_r <= 1'b1;
                        err_r        <= addr_err_s;
                        load_ok_r    <= !acc_write_s && !addr_err_s;
                    end else begin
                        cnt_r <= cnt_r - {{(DMEM_LAT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        state_r      <= ST_IDLE;
                        resp_valid_r <= 1'b0;
                        err_r        <= 1'b0;
                        load_ok_r    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Load data is the registered array word, gated to zero outside a good load
    assign bus.req_ready  = (state_r == ST_IDLE);
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_err   = err_r;
    assign bus.resp_rdata = load_ok_r ? arr_rdata_s : 32'h0000_0000;

endmodule
